// File: rtl/sync_up_down_counter.sv
// Modulo-MODULUS up/down counter with parallel load and a one-cycle SETTLE
// state that is inserted whenever the direction changes while counting.
module sync_up_down_counter #(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             M,
  input  logic             load,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_bar,
  output logic             tc,
  output logic             wrap,
  output logic             dir_chg
);

  typedef enum logic [1:0] {
    UP     = 2'd0,
    DOWN   = 2'd1,
    SETTLE = 2'd2
  } state_t;

  localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);

  state_t           state;
  logic             m_q;
  logic [WIDTH-1:0] load_val;

  // Load values outside the count range saturate to the top of the range.
  assign load_val = ({1'b0, D} < MOD_W) ? D : MAX_Q;

  assign Q_bar = ~Q;
  assign tc    = ((state == UP) && (Q == MAX_Q)) ||
                 ((state == DOWN) && (Q == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Q       <= '0;
      m_q     <= 1'b0;
      state   <= UP;
      wrap    <= 1'b0;
      dir_chg <= 1'b0;
    end else begin
      wrap    <= 1'b0;
      dir_chg <= 1'b0;
      if (load) begin
        Q     <= load_val;
        m_q   <= M;
        state <= M ? DOWN : UP;
      end else if (!en) begin
        m_q   <= M;
        state <= M ? DOWN : UP;
      end else if (state == SETTLE) begin
        // Leave SETTLE only once the direction input has been stable for an edge.
        if (M == m_q) begin
          state <= m_q ? DOWN : UP;
        end else begin
          m_q     <= M;
          dir_chg <= 1'b1;
        end
      end else if (M != m_q) begin
        state   <= SETTLE;
        m_q     <= M;
        dir_chg <= 1'b1;
      end else if (state == UP) begin
        if (Q == MAX_Q) begin
          Q    <= '0;
          wrap <= 1'b1;
        end else begin
          Q <= Q + 1'b1;
        end
      end else begin
        if (Q == '0) begin
          Q    <= MAX_Q;
          wrap <= 1'b1;
        end else begin
          Q <= Q - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sync_up_down_counter.sv
// Directed bench for sync_up_down_counter: one instance at MODULUS=8 and one
// at MODULUS=6, each driven by its own input set and checked against hand values.
module tb_sync_up_down_counter;

  logic       clk;
  logic       rst_a, en_a, m_a, load_a;
  logic [2:0] d_a, q_a, qb_a;
  logic       tc_a, wrap_a, dir_a;
  logic       rst_b, en_b, m_b, load_b;
  logic [2:0] d_b, q_b, qb_b;
  logic       tc_b, wrap_b, dir_b;

  int checks = 0;
  int errors = 0;

  sync_up_down_counter #(.WIDTH(3), .MODULUS(8)) dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .M(m_a), .load(load_a), .D(d_a),
    .Q(q_a), .Q_bar(qb_a), .tc(tc_a), .wrap(wrap_a), .dir_chg(dir_a)
  );

  sync_up_down_counter #(.WIDTH(3), .MODULUS(6)) dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .M(m_b), .load(load_b), .D(d_b),
    .Q(q_b), .Q_bar(qb_b), .tc(tc_b), .wrap(wrap_b), .dir_chg(dir_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one instance's inputs, then step to 1 time unit after the next rising edge.
  task automatic applyStimulus(input bit sel_b, input logic en_i, input logic m_i,
                               input logic load_i, input logic [2:0] d_i);
    if (sel_b) begin
      en_b = en_i; m_b = m_i; load_b = load_i; d_b = d_i;
    end else begin
      en_a = en_i; m_a = m_i; load_a = load_i; d_a = d_i;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkA(input string tag, input int q, input int wr, input int t, input int dc);
    checkOutput({tag, ".Q"}, int'(q_a), q);
    checkOutput({tag, ".wrap"}, int'(wrap_a), wr);
    checkOutput({tag, ".tc"}, int'(tc_a), t);
    checkOutput({tag, ".dir_chg"}, int'(dir_a), dc);
  endtask

  task automatic checkB(input string tag, input int q, input int wr, input int t, input int dc);
    checkOutput({tag, ".Q"}, int'(q_b), q);
    checkOutput({tag, ".wrap"}, int'(wrap_b), wr);
    checkOutput({tag, ".tc"}, int'(tc_b), t);
    checkOutput({tag, ".dir_chg"}, int'(dir_b), dc);
  endtask

  initial begin
    rst_a = 1'b1; en_a = 1'b0; m_a = 1'b0; load_a = 1'b0; d_a = 3'd0;
    rst_b = 1'b1; en_b = 1'b0; m_b = 1'b0; load_b = 1'b0; d_b = 3'd0;
    #3;
    checkA("rst_async", 0, 0, 0, 0);
    checkOutput("rst_async.Q_bar", int'(qb_a), 7);
    checkB("rst_async_b", 0, 0, 0, 0);

    // Inputs are ignored while reset is held.
    applyStimulus(0, 1'b1, 1'b1, 1'b1, 3'd5);
    checkA("rst_hold", 0, 0, 0, 0);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Up count through a full wrap.
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(0, 1'b1, 1'b0, 1'b0, 3'd0);
      checkA($sformatf("up%0d", i), i % 8, (i == 8) ? 1 : 0, ((i % 8) == 7) ? 1 : 0, 0);
    end
    for (int i = 0; i < 4; i++) applyStimulus(0, 1'b1, 1'b0, 1'b0, 3'd0);
    checkA("up_to5", 5, 0, 0, 0);
    rst_a = 1'b1;
    #1;
    checkA("rst_mid_count", 0, 0, 0, 0);
    checkOutput("rst_mid_count.Q_bar", int'(qb_a), 7);
    @(posedge clk);
    #1;
    rst_a = 1'b0;

    // Direction change while counting goes through SETTLE.
    for (int i = 0; i < 3; i++) applyStimulus(0, 1'b1, 1'b0, 1'b0, 3'd0);
    checkA("pre_settle", 3, 0, 0, 0);
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 3'd0);
    checkA("settle_e1", 3, 0, 0, 1);
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 3'd0);
    checkA("settle_e2", 3, 0, 0, 0);
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 3'd0);
    checkA("settle_e3", 2, 0, 0, 0);
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 3'd0);
    checkA("settle_e4", 1, 0, 0, 0);
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 3'd0);
    checkA("settle_again", 1, 0, 0, 1);
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 3'd0);
    checkA("settle_flip", 1, 0, 0, 1);
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 3'd0);
    checkA("settle_exit", 1, 0, 0, 0);
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 3'd0);
    checkA("down_zero", 0, 0, 1, 0);
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 3'd0);
    checkA("down_wrap", 7, 1, 0, 0);
    rst_a = 1'b1;
    #1;
    checkA("rst_kills_wrap", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_a = 1'b0;

    // Reset in the middle of SETTLE drops dir_chg at once.
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 3'd0);
    checkA("settle_pre_rst", 0, 0, 0, 1);
    rst_a = 1'b1;
    #1;
    checkA("rst_kills_settle", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_a = 1'b0;

    // Hold with en=0 while M toggles: no SETTLE, new direction applies directly.
    applyStimulus(0, 1'b0, 1'b0, 1'b1, 3'd4);
    checkA("load4", 4, 0, 0, 0);
    applyStimulus(0, 1'b0, 1'b1, 1'b0, 3'd0);
    checkA("hold1", 4, 0, 0, 0);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 3'd0);
    checkA("hold2", 4, 0, 0, 0);
    applyStimulus(0, 1'b0, 1'b1, 1'b0, 3'd0);
    checkA("hold3", 4, 0, 0, 0);
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 3'd0);
    checkA("hold_then_down", 3, 0, 0, 0);

    // MODULUS=6 instance: down count from reset.
    applyStimulus(1, 1'b0, 1'b1, 1'b0, 3'd0);
    checkB("b_down_idle", 0, 0, 1, 0);
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 3'd0);
    checkB("b_down_wrap", 5, 1, 0, 0);
    checkOutput("b_down_wrap.Q_bar", int'(qb_b), 2);
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 3'd0);
    checkB("b_down4", 4, 0, 0, 0);
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 3'd0);
    checkB("b_down3", 3, 0, 0, 0);

    // Load saturation and load-with-direction-change.
    applyStimulus(1, 1'b0, 1'b1, 1'b1, 3'd7);
    checkB("b_load_sat7", 5, 0, 0, 0);
    applyStimulus(1, 1'b1, 1'b0, 1'b1, 3'd2);
    checkB("b_load2_dir", 2, 0, 0, 0);
    applyStimulus(1, 1'b1, 1'b0, 1'b0, 3'd0);
    checkB("b_up3", 3, 0, 0, 0);
    applyStimulus(1, 1'b1, 1'b0, 1'b0, 3'd0);
    checkB("b_up4", 4, 0, 0, 0);
    applyStimulus(1, 1'b1, 1'b0, 1'b0, 3'd0);
    checkB("b_up5", 5, 0, 1, 0);
    applyStimulus(1, 1'b1, 1'b0, 1'b0, 3'd0);
    checkB("b_up_wrap", 0, 1, 0, 0);
    applyStimulus(1, 1'b1, 1'b0, 1'b1, 3'd6);
    checkB("b_load_sat6", 5, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
